// File: rtl/mont_sched_pkg.sv
// mont_sched_pkg
//   Shared types and default sizing for the Montgomery-reduce scheduler.
//   state_t           : scheduler FSM states
//   DEF_*             : default configuration values used by the top
//   *_CNT_W / ADDR_W  : counter/address widths for the default configuration
package mont_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_REGISTER_SIZE   = 32;
  localparam int DEF_NUM_BLOCKS      = 256;
  localparam int DEF_OUT_BLOCKS      = 128;
  localparam int DEF_CONST_BLOCKS    = 128;
  localparam int DEF_NUM_REQ         = 2;
  localparam int DEF_WATCHDOG_CYCLES = 4096;

  localparam int IN_CNT_W     = $clog2(DEF_NUM_BLOCKS);
  localparam int OUT_CNT_W    = $clog2(DEF_OUT_BLOCKS);
  localparam int CONST_ADDR_W = $clog2(DEF_CONST_BLOCKS);

endpackage

// File: rtl/montgomery_reduce_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: grants the first requester at or after
//   rr_ptr, wrapping around. Produces both a one-hot grant and its index.
//   req       in   NUM_REQ          request vector
//   rr_ptr    in   $clog2(NUM_REQ)  highest-priority requester this round
//   grant     out  NUM_REQ          one-hot winner (0 when nobody requests)
//   grant_idx out  $clog2(NUM_REQ)  index of the winner
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/montgomery_reduce_scheduler.sv
// montgomery_reduce_scheduler
//   Shares one montgomery_reduce instance between NUM_REQ requesters.
//   Round-robin arbitration, T-block forwarding, k/N constant addressing and
//   result routing back to the owner. One reduction in flight at a time.
//   Optional feature macro: MONT_SCHED_WATCHDOG_EN (result watchdog).
// Ports
//   clk_in / rst_in          clock, async active-high reset
//   req_in                   per-requester level request
//   grant_out                one-hot owner for the whole operation
//   req_valid_in/block_in    per-requester T block strobe and data slices
//   red_valid_out/T_block    registered T block towards the reducer
//   red_consumed_k/N_in      reducer consumed a constant block
//   k_addr_out / n_addr_out  constant block addresses (wrap at CONST_BLOCKS)
//   red_valid_in/block_in    result block from the reducer
//   resp_valid_out/block     registered result towards the owner
//   busy_out                 operation in progress
//   proto_err_out            sticky protocol violation flag
//   timeout_out              one-cycle watchdog abort pulse
module montgomery_reduce_scheduler
  import mont_sched_pkg::*;
#(
  parameter int REGISTER_SIZE   = DEF_REGISTER_SIZE,
  parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
  parameter int OUT_BLOCKS      = DEF_OUT_BLOCKS,
  parameter int CONST_BLOCKS    = DEF_CONST_BLOCKS,
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_REQ-1:0]                req_in,
  output logic [NUM_REQ-1:0]                grant_out,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0]  req_block_in,
  output logic                              red_valid_out,
  output logic [REGISTER_SIZE-1:0]          red_T_block_out,
  input  logic                              red_consumed_k_in,
  input  logic                              red_consumed_N_in,
  output logic [$clog2(CONST_BLOCKS)-1:0]   k_addr_out,
  output logic [$clog2(CONST_BLOCKS)-1:0]   n_addr_out,
  input  logic                              red_valid_in,
  input  logic [REGISTER_SIZE-1:0]          red_block_in,
  output logic [NUM_REQ-1:0]                resp_valid_out,
  output logic [REGISTER_SIZE-1:0]          resp_block_out,
  output logic                              busy_out,
  output logic                              proto_err_out,
  output logic                              timeout_out
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int IN_W   = $clog2(NUM_BLOCKS);
  localparam int OUT_W  = $clog2(OUT_BLOCKS);
  localparam int ADDR_W = $clog2(CONST_BLOCKS);

  state_t state, next_state;

  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         owner_idx;
  logic [PTR_W-1:0]         pick_idx;
  logic [NUM_REQ-1:0]       pick_grant;
  logic [IN_W-1:0]          in_cnt;
  logic [OUT_W-1:0]         out_cnt;
  logic [REGISTER_SIZE-1:0] owner_block;

  logic start_op;
  logic t_accept;
  logic last_t;
  logic r_accept;
  logic last_r;
  logic wd_fire;
  logic op_done;
  logic bad_req;
  logic bad_red;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_in),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign busy_out    = (state != IDLE);
  assign owner_block = req_block_in[int'(owner_idx)*REGISTER_SIZE +: REGISTER_SIZE];

  // Only the owner may stream T blocks, and only while loading; results are
  // only legal while waiting. Anything else is dropped and flagged.
  always_comb begin
    start_op = (state == IDLE) && (|req_in);
    t_accept = (state == LOAD) && req_valid_in[owner_idx];
    last_t   = t_accept && (in_cnt == IN_W'(NUM_BLOCKS - 1));
    r_accept = (state == WAIT) && red_valid_in;
    last_r   = r_accept && (out_cnt == OUT_W'(OUT_BLOCKS - 1));
    op_done  = last_r || wd_fire;
    bad_req  = |(req_valid_in & ~((state == LOAD) ? grant_out : '0));
    bad_red  = red_valid_in && (state != WAIT);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_op) next_state = LOAD;
      LOAD:    if (last_t)   next_state = WAIT;
      WAIT:    if (op_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef MONT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  // Counts consecutive result-free cycles in WAIT; any result restarts it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_cnt      <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= wd_fire;
      if (state != WAIT || red_valid_in) wd_cnt <= '0;
      else                               wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_fire = (state == WAIT) && !red_valid_in &&
                   (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
`else
  assign wd_fire     = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_out       <= '0;
      owner_idx       <= '0;
      rr_ptr          <= '0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      k_addr_out      <= '0;
      n_addr_out      <= '0;
      red_valid_out   <= 1'b0;
      red_T_block_out <= '0;
      resp_valid_out  <= '0;
      resp_block_out  <= '0;
      proto_err_out   <= 1'b0;
    end else begin
      red_valid_out  <= t_accept;
      resp_valid_out <= r_accept ? grant_out : '0;
      if (t_accept) red_T_block_out <= owner_block;
      if (r_accept) resp_block_out  <= red_block_in;
      if (bad_req || bad_red) proto_err_out <= 1'b1;

      if (start_op) begin
        grant_out  <= pick_grant;
        owner_idx  <= pick_idx;
        in_cnt     <= '0;
        out_cnt    <= '0;
        k_addr_out <= '0;
        n_addr_out <= '0;
      end else begin
        if (t_accept) in_cnt  <= in_cnt + IN_W'(1);
        if (r_accept) out_cnt <= out_cnt + OUT_W'(1);
        // The finishing owner becomes lowest priority for the next round.
        if (op_done) begin
          grant_out <= '0;
          rr_ptr    <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
        end
      end

      // The N wrap lets each reducer pass (multiply/compare/subtract) reread
      // N from block 0 without any help from the scheduler.
      if (state != IDLE && red_consumed_k_in)
        k_addr_out <= (k_addr_out == ADDR_W'(CONST_BLOCKS - 1)) ? '0 : k_addr_out + ADDR_W'(1);
      if (state != IDLE && red_consumed_N_in)
        n_addr_out <= (n_addr_out == ADDR_W'(CONST_BLOCKS - 1)) ? '0 : n_addr_out + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_montgomery_reduce_scheduler.sv
// tb_montgomery_reduce_scheduler
//   Table of back-to-back operations (arbitration order, forwarding, routing,
//   constant address wrap) followed by hand-written corner sequences:
//   idle consumed pulses, protocol error, async reset in WAIT and, when
//   MONT_SCHED_WATCHDOG_EN is defined, the watchdog abort.
module tb_montgomery_reduce_scheduler;

  localparam int NB = 256;
  localparam int OB = 128;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  req_in = '0;
  logic [1:0]  grant_out;
  logic [1:0]  req_valid_in = '0;
  logic [63:0] req_block_in = '0;
  logic        red_valid_out;
  logic [31:0] red_T_block_out;
  logic        red_consumed_k_in = 1'b0;
  logic        red_consumed_N_in = 1'b0;
  logic [6:0]  k_addr_out;
  logic [6:0]  n_addr_out;
  logic        red_valid_in = 1'b0;
  logic [31:0] red_block_in = '0;
  logic [1:0]  resp_valid_out;
  logic [31:0] resp_block_out;
  logic        busy_out;
  logic        proto_err_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;

  montgomery_reduce_scheduler #(
    .REGISTER_SIZE   (32),
    .NUM_BLOCKS      (NB),
    .OUT_BLOCKS      (OB),
    .CONST_BLOCKS    (128),
    .NUM_REQ         (2),
    .WATCHDOG_CYCLES (16)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_in            (req_in),
    .grant_out         (grant_out),
    .req_valid_in      (req_valid_in),
    .req_block_in      (req_block_in),
    .red_valid_out     (red_valid_out),
    .red_T_block_out   (red_T_block_out),
    .red_consumed_k_in (red_consumed_k_in),
    .red_consumed_N_in (red_consumed_N_in),
    .k_addr_out        (k_addr_out),
    .n_addr_out        (n_addr_out),
    .red_valid_in      (red_valid_in),
    .red_block_in      (red_block_in),
    .resp_valid_out    (resp_valid_out),
    .resp_block_out    (resp_block_out),
    .busy_out          (busy_out),
    .proto_err_out     (proto_err_out),
    .timeout_out       (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no end, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_grant;
    int         n_pulses;
    int         k_pulses;
    logic [6:0] exp_n;
    logic [6:0] exp_k;
  } op_vec_t;

  op_vec_t vecs[6];

  function automatic logic [31:0] tPat(input int e, input int j);
    return 32'hC0DE_0000 ^ 32'(e << 12) ^ 32'(j * 37);
  endfunction

  function automatic logic [31:0] rPat(input int e, input int j);
    return 32'h5A5A_0000 + 32'(e * 1000 + j);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [1:0] rv, input logic [63:0] blk,
                               input logic rvld, input logic [31:0] rblk,
                               input logic ck, input logic cn);
    req_valid_in      = rv;
    req_block_in      = blk;
    red_valid_in      = rvld;
    red_block_in      = rblk;
    red_consumed_k_in = ck;
    red_consumed_N_in = cn;
    @(posedge clk_in);
    #1;
  endtask

  task automatic runOp(input int e, input logic [1:0] next_req);
    int          g;
    int          fwd_bad;
    int          resp_bad;
    logic [31:0] blk;
    logic [31:0] r;
    g = 0;
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput($sformatf("op%0d_grant", e), 32'(grant_out), 32'(vecs[e].exp_grant));
    checkOutput($sformatf("op%0d_busy", e), 32'(busy_out), 32'd1);
    checkOutput($sformatf("op%0d_addr_clear", e), {18'd0, k_addr_out, n_addr_out}, 32'd0);

    fwd_bad = 0;
    for (int j = 0; j < NB; j++) begin
      blk = tPat(e, j);
      applyStimulus(vecs[e].exp_grant,
                    vecs[e].exp_grant[1] ? {blk, ~blk} : {~blk, blk},
                    1'b0, 32'd0, g < vecs[e].k_pulses, g < vecs[e].n_pulses);
      g++;
      if (red_valid_out !== 1'b1 || red_T_block_out !== blk) fwd_bad++;
    end
    checkOutput($sformatf("op%0d_fwd_bad", e), 32'(fwd_bad), 32'd0);
    checkOutput($sformatf("op%0d_busy_wait", e), 32'(busy_out), 32'd1);

    req_in = next_req;
    resp_bad = 0;
    for (int j = 0; j < OB; j++) begin
      r = rPat(e, j);
      applyStimulus(2'b00, 64'd0, 1'b1, r, g < vecs[e].k_pulses, g < vecs[e].n_pulses);
      g++;
      if (resp_valid_out !== vecs[e].exp_grant || resp_block_out !== r) resp_bad++;
      if (j > 0 && red_valid_out !== 1'b0) resp_bad++;
    end
    checkOutput($sformatf("op%0d_resp_bad", e), 32'(resp_bad), 32'd0);
    checkOutput($sformatf("op%0d_grant_drop", e), 32'(grant_out), 32'd0);
    checkOutput($sformatf("op%0d_idle", e), 32'(busy_out), 32'd0);
    checkOutput($sformatf("op%0d_n_addr", e), 32'(n_addr_out), 32'(vecs[e].exp_n));
    checkOutput($sformatf("op%0d_k_addr", e), 32'(k_addr_out), 32'(vecs[e].exp_k));
    checkOutput($sformatf("op%0d_proto", e), 32'(proto_err_out), 32'd0);
  endtask

  initial begin
    int bad;
    logic [1:0] nreq;

    // Arbitration order follows rr_ptr starting at 0, moving to owner+1.
    // Address expectations: pulses mod 128 (300->44, 128->0, 130->2, 383->127).
    vecs[0] = '{req: 2'b10, exp_grant: 2'b10, n_pulses: 300, k_pulses: 5,   exp_n: 7'd44,  exp_k: 7'd5};
    vecs[1] = '{req: 2'b11, exp_grant: 2'b01, n_pulses: 128, k_pulses: 130, exp_n: 7'd0,   exp_k: 7'd2};
    vecs[2] = '{req: 2'b11, exp_grant: 2'b10, n_pulses: 0,   k_pulses: 127, exp_n: 7'd0,   exp_k: 7'd127};
    vecs[3] = '{req: 2'b01, exp_grant: 2'b01, n_pulses: 383, k_pulses: 0,   exp_n: 7'd127, exp_k: 7'd0};
    vecs[4] = '{req: 2'b01, exp_grant: 2'b01, n_pulses: 0,   k_pulses: 0,   exp_n: 7'd0,   exp_k: 7'd0};
    vecs[5] = '{req: 2'b10, exp_grant: 2'b10, n_pulses: 3,   k_pulses: 1,   exp_n: 7'd3,   exp_k: 7'd1};

    #12;
    checkOutput("reset_grant", 32'(grant_out), 32'd0);
    checkOutput("reset_busy", 32'(busy_out), 32'd0);
    checkOutput("reset_strobes", {28'd0, resp_valid_out, red_valid_out, timeout_out}, 32'd0);
    checkOutput("reset_addr", {18'd0, k_addr_out, n_addr_out}, 32'd0);
    checkOutput("reset_proto", 32'(proto_err_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    req_in = vecs[0].req;

    for (int e = 0; e < 6; e++) begin
      nreq = (e < 5) ? vecs[e + 1].req : 2'b00;
      runOp(e, nreq);
    end

    // Consumed pulses while idle must not move the addresses.
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("idle_consumed_n", 32'(n_addr_out), 32'd3);
    checkOutput("idle_consumed_k", 32'(k_addr_out), 32'd1);

    // Non-owner T block: dropped and flagged until reset.
    req_in = 2'b10;
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    req_in = 2'b00;
    checkOutput("perr_grant", 32'(grant_out), 32'd2);
    applyStimulus(2'b01, {32'h1111_1111, 32'hDEAD_BEEF}, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("perr_not_fwd", 32'(red_valid_out), 32'd0);
    checkOutput("perr_flag", 32'(proto_err_out), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("perr_sticky", 32'(proto_err_out), 32'd1);
    rst_in = 1'b1;
    #2;
    checkOutput("perr_cleared", 32'(proto_err_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Async reset in WAIT after 50 results.
    req_in = 2'b01;
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    req_in = 2'b00;
    checkOutput("rst_op_grant", 32'(grant_out), 32'd1);
    for (int j = 0; j < NB; j++) applyStimulus(2'b01, {32'd0, tPat(9, j)}, 1'b0, 32'd0, 1'b0, 1'b1);
    bad = 0;
    for (int j = 0; j < 50; j++) begin
      applyStimulus(2'b00, 64'd0, 1'b1, rPat(9, j), 1'b0, 1'b0);
      if (resp_valid_out !== 2'b01 || resp_block_out !== rPat(9, j)) bad++;
    end
    checkOutput("rst_op_resp_bad", 32'(bad), 32'd0);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("async_rst_grant", 32'(grant_out), 32'd0);
    checkOutput("async_rst_busy", 32'(busy_out), 32'd0);
    checkOutput("async_rst_strobes", {30'd0, resp_valid_out}, 32'd0);
    checkOutput("async_rst_data", resp_block_out | red_T_block_out, 32'd0);
    checkOutput("async_rst_n_addr", 32'(n_addr_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 64'd0, 1'b1, 32'hFFFF_0000, 1'b0, 1'b0);
      if (resp_valid_out !== 2'b00 || busy_out !== 1'b0) bad++;
    end
    checkOutput("post_rst_no_resp", 32'(bad), 32'd0);
    checkOutput("post_rst_idle_result_err", 32'(proto_err_out), 32'd1);

`ifdef MONT_SCHED_WATCHDOG_EN
    rst_in = 1'b1;
    #2;
    @(negedge clk_in);
    rst_in = 1'b0;
    req_in = 2'b01;
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    req_in = 2'b00;
    for (int j = 0; j < NB; j++) applyStimulus(2'b01, {32'd0, tPat(7, j)}, 1'b0, 32'd0, 1'b0, 1'b0);
    bad = 0;
    for (int c = 1; c < 16; c++) begin
      applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      if (timeout_out !== 1'b0 || busy_out !== 1'b1) bad++;
    end
    checkOutput("wd_early", 32'(bad), 32'd0);
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("wd_pulse", 32'(timeout_out), 32'd1);
    checkOutput("wd_grant", 32'(grant_out), 32'd0);
    checkOutput("wd_busy", 32'(busy_out), 32'd0);
    applyStimulus(2'b00, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("wd_pulse_end", 32'(timeout_out), 32'd0);
`else
    checkOutput("no_wd_timeout", 32'(timeout_out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
